// File: rtl/zvc_line_scheduler_pkg.sv
// Purpose: shared constants, default parameters and FSM encoding for the ZVC line scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default geometry (DEF_*), LIFM_LINE_W / MT_LINE_W line widths, state_t (IDLE=0, RUN=1, DRAIN=2).
package zvc_pkg;

  localparam int DEF_WORD_WIDTH    = 8;
  localparam int DEF_LINE_SIZE     = 128;
  localparam int DEF_DIST_WIDTH    = 7;
  localparam int DEF_MAX_LIFM_RSIZ = 4;
  localparam int DEF_COMP_LATENCY  = 2;
  localparam int DEF_FIFO_DEPTH    = 4;

  localparam int LIFM_LINE_W = DEF_LINE_SIZE * DEF_WORD_WIDTH;
  localparam int MT_LINE_W   = DEF_LINE_SIZE * DEF_DIST_WIDTH * DEF_MAX_LIFM_RSIZ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/zvc_line_scheduler_if.sv
// Purpose: line bus of the scheduler: upstream input, compressor side-channel, downstream output.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream; compressor side never stalls.
// Modports: slave = scheduler side, master = environment side (upstream, compressor, downstream).
interface zvc_line_scheduler_if
  import zvc_pkg::*;
#(
  parameter int LIFM_W = LIFM_LINE_W,
  parameter int MT_W   = MT_LINE_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [LIFM_W-1:0] in_lifm;
  logic [MT_W-1:0]   in_mt;

  logic [LIFM_W-1:0] comp_lifm_line;
  logic [MT_W-1:0]   comp_mt_line;
  logic [LIFM_W-1:0] comp_lifm_comp;
  logic [MT_W-1:0]   comp_mt_comp;

  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [LIFM_W-1:0] out_lifm;
  logic [MT_W-1:0]   out_mt;

  modport slave (
    input  in_valid, in_last, in_lifm, in_mt, comp_lifm_comp, comp_mt_comp, out_ready,
    output in_ready, comp_lifm_line, comp_mt_line, out_valid, out_last, out_lifm, out_mt
  );

  modport master (
    output in_valid, in_last, in_lifm, in_mt, comp_lifm_comp, comp_mt_comp, out_ready,
    input  in_ready, comp_lifm_line, comp_mt_line, out_valid, out_last, out_lifm, out_mt
  );

endinterface

// File: rtl/zvc_line_scheduler_fifo.sv
// Purpose: first-word-fall-through FIFO of parameterised width holding compressed lines.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full (credits guarantee it).
// Ports: clk, reset_n (sync, active-low), push/push_dat, pop, pop_dat (head), count, empty, full.
module zvc_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_dat = mem[rd_ptr];

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zvc_line_scheduler.sv
// Purpose: sequences LIFM/mapping-table lines through a non-stalling ZVC compressor into an output FIFO.
// Latency: accept -> out_valid is COMP_LATENCY+1 cycles minimum; one line per cycle sustained.
// Backpressure: in_ready only while FIFO_DEPTH - fifo_count - inflight > 0, so the FIFO cannot overflow.
// Ports: clk, reset_n (sync, active-low), start, bus (zvc_line_scheduler_if.slave), busy, done.
// Optional: `define ZVC_SCHED_STATS_EN adds stat_lines / stat_stalls (32-bit, saturating, cleared on start).
module zvc_line_scheduler
  import zvc_pkg::*;
#(
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int LINE_SIZE     = DEF_LINE_SIZE,
  parameter int DIST_WIDTH    = DEF_DIST_WIDTH,
  parameter int MAX_LIFM_RSIZ = DEF_MAX_LIFM_RSIZ,
  parameter int COMP_LATENCY  = DEF_COMP_LATENCY,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  zvc_line_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 done
`ifdef ZVC_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_lines,
  output logic [31:0]          stat_stalls
`endif
);

  localparam int LIFM_W = LINE_SIZE * WORD_WIDTH;
  localparam int MT_W   = LINE_SIZE * DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int ENT_W  = 1 + LIFM_W + MT_W;
  localparam int CW     = $clog2(FIFO_DEPTH+1);

  state_t                  state, state_nxt;
  logic [COMP_LATENCY-1:0] vld_chain;
  logic [COMP_LATENCY-1:0] last_chain;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             occupancy;
  logic                    fifo_empty, fifo_full;
  logic                    accept, push, pop;
  logic [ENT_W-1:0]        head;

  // Compressor inputs are a straight pass-through; the valid chain decides what gets captured.
  assign bus.comp_lifm_line = bus.in_lifm;
  assign bus.comp_mt_line   = bus.in_mt;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < COMP_LATENCY; i++) inflight = inflight + CW'(vld_chain[i]);
  end

  // One extra bit so the sum cannot wrap when comparing against FIFO_DEPTH.
  assign occupancy    = {1'b0, fifo_count} + {1'b0, inflight};
  assign bus.in_ready = (state == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = vld_chain[COMP_LATENCY-1];
  assign bus.out_valid = !fifo_empty;
  assign pop          = bus.out_valid && bus.out_ready;
  assign busy         = (state != IDLE);

  // Head is masked when empty so the data outputs read 0 after reset.
  assign bus.out_last = bus.out_valid ? head[ENT_W-1] : 1'b0;
  assign bus.out_lifm = bus.out_valid ? head[ENT_W-2 -: LIFM_W] : '0;
  assign bus.out_mt   = bus.out_valid ? head[MT_W-1:0] : '0;

  zvc_sched_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({last_chain[COMP_LATENCY-1], bus.comp_lifm_comp, bus.comp_mt_comp}),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && bus.in_last) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_empty && !pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      vld_chain  <= '0;
      last_chain <= '0;
    end else begin
      state         <= state_nxt;
      done          <= (state == DRAIN) && (state_nxt == IDLE);
      vld_chain[0]  <= accept;
      last_chain[0] <= accept && bus.in_last;
      for (int i = 1; i < COMP_LATENCY; i++) begin
        vld_chain[i]  <= vld_chain[i-1];
        last_chain[i] <= last_chain[i-1];
      end
    end
  end

  // Credits bound fifo_count + inflight, so a capture can never meet a full FIFO.
  always_ff @(posedge clk) begin
    if (reset_n) assert (!(push && fifo_full));
  end

`ifdef ZVC_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n || (state == IDLE && start)) begin
      stat_lines  <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept && stat_lines != '1) stat_lines <= stat_lines + 32'd1;
      if (bus.out_valid && !bus.out_ready && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule
